// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encoding and slice width.
package nibble_serial_adder_pkg;

  localparam int NIB_BITS = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// The ovf signal exists only when SIGNED_OVF_EN is defined.
interface nibble_serial_adder_if #(parameter int WIDTH = 16);

  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carryInput;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] sum;
  logic             carryOutput;
`ifdef SIGNED_OVF_EN
  logic             ovf;

  modport master (
    output inValid, a, b, carryInput, outReady,
    input  inReady, outValid, sum, carryOutput, ovf
  );

  modport slave (
    input  inValid, a, b, carryInput, outReady,
    output inReady, outValid, sum, carryOutput, ovf
  );
`else
  modport master (
    output inValid, a, b, carryInput, outReady,
    input  inReady, outValid, sum, carryOutput
  );

  modport slave (
    input  inValid, a, b, carryInput, outReady,
    output inReady, outValid, sum, carryOutput
  );
`endif

endinterface

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry slice. Also exposes the carry into the MSB
// so the parent can form a signed-overflow flag on the top nibble.
module nibble_add4
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_BITS-1:0] i_a,
  input  logic [NIB_BITS-1:0] i_b,
  input  logic                i_cin,
  output logic [NIB_BITS-1:0] o_sum,
  output logic                o_cout,
  output logic                o_c_msb
);

  logic [NIB_BITS:0] w_c;

  // Bit-by-bit ripple of the carry chain.
  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < NIB_BITS; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout  = w_c[NIB_BITS];
  assign o_c_msb = w_c[NIB_BITS-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder built around one 4-bit slice; the carry between
// nibbles lives in a register. Optional feature macro: SIGNED_OVF_EN (adds ovf).
//
// state  | meaning
// IDLE   | waiting for operands, inReady=1, sum holds last result
// RUN    | one nibble added per edge, idx 0..NIB-1
// DONE   | result presented, outValid=1, waiting for outReady
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  nibble_serial_adder_if.slave  bus
);

  localparam int NIB  = WIDTH / NIB_BITS;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

  if ((WIDTH % NIB_BITS) != 0 || WIDTH < 8) begin : g_width_chk
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
  end

  logic [1:0]          r_state;
  logic [IDXW-1:0]     r_idx;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic [WIDTH-1:0]    r_sum;
  logic                r_carry;
  logic                r_cout;

  logic [NIB_BITS-1:0] w_a_nib;
  logic [NIB_BITS-1:0] w_b_nib;
  logic [NIB_BITS-1:0] w_s_nib;
  logic                w_co;

  assign w_a_nib = r_a[r_idx*NIB_BITS +: NIB_BITS];
  assign w_b_nib = r_b[r_idx*NIB_BITS +: NIB_BITS];

`ifdef SIGNED_OVF_EN
  logic r_ovf;
  logic w_c_msb;
`else
  logic w_c_msb_unused;
`endif

  nibble_add4 u_slice (
    .i_a     (w_a_nib),
    .i_b     (w_b_nib),
    .i_cin   (r_carry),
    .o_sum   (w_s_nib),
    .o_cout  (w_co),
`ifdef SIGNED_OVF_EN
    .o_c_msb (w_c_msb)
`else
    .o_c_msb (w_c_msb_unused)
`endif
  );

  // FSM, operand capture and per-nibble accumulation of the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.inValid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.carryInput;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[r_idx*NIB_BITS +: NIB_BITS] <= w_s_nib;
          r_carry <= w_co;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == IDX_LAST) begin
            r_cout  <= w_co;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.outReady) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SIGNED_OVF_EN
  // Signed overflow: carry into the top bit disagrees with carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_RUN && r_idx == IDX_LAST) begin
      r_ovf <= w_c_msb ^ w_co;
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.inReady     = (r_state == S_IDLE);
  assign bus.outValid    = (r_state == S_DONE);
  assign bus.sum         = r_sum;
  assign bus.carryOutput = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed operations with literal expectations,
// plus a transaction-level model checked against the outputs every cycle.
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(W)) bus();

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           due;
  } res_t;

  res_t         q[$];
  logic [W-1:0] last_sum;
  logic         last_cout;
  logic         last_ovf;
  bit           model_on = 0;
  bit           busy;
  bit           exp_ov;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input int due);
    logic [W:0] full;
    res_t r;
    full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
    r.due  = due;
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Compare outputs against the model, then advance the model for the next edge.
  always @(negedge clk) begin
    busy   = (q.size() > 0);
    exp_ov = busy && (cyc >= q[0].due);
    if (model_on) begin
      chk("m_inReady", W'(bus.inReady), W'(!busy));
      chk("m_outValid", W'(bus.outValid), W'(exp_ov));
      if (exp_ov) begin
        chk("m_sum", bus.sum, q[0].sum);
        chk("m_cout", W'(bus.carryOutput), W'(q[0].cout));
`ifdef SIGNED_OVF_EN
        chk("m_ovf", W'(bus.ovf), W'(q[0].ovf));
`endif
      end else if (!busy) begin
        chk("m_idle_sum", bus.sum, last_sum);
        chk("m_idle_cout", W'(bus.carryOutput), W'(last_cout));
`ifdef SIGNED_OVF_EN
        chk("m_idle_ovf", W'(bus.ovf), W'(last_ovf));
`endif
      end
    end
    if (rst) begin
      q.delete();
      last_sum  = '0;
      last_cout = 1'b0;
      last_ovf  = 1'b0;
      model_on  = 1;
    end else if (model_on) begin
      if (!busy && bus.inValid) begin
        q.push_back(model(bus.a, bus.b, bus.carryInput, cyc + 1 + NIB));
      end else if (exp_ov && bus.outReady) begin
        last_sum  = q[0].sum;
        last_cout = q[0].cout;
        last_ovf  = q[0].ovf;
        void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation; lat counts edges with the acceptance edge as edge 1.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] xs, input logic xc, input logic xo,
                        input int hold, input bit scramble, output int lat);
    int n;
    n = 0;
    while (!bus.inReady && n < 50) begin
      tick();
      n++;
    end
    chk("op_inReady", W'(bus.inReady), W'(1));
    bus.a          = a;
    bus.b          = b;
    bus.carryInput = cin;
    bus.inValid    = 1'b1;
    tick();
    bus.inValid = 1'b0;
    lat = 1;
    while (!bus.outValid && lat < 50) begin
      if (scramble) begin
        bus.a          = W'($urandom);
        bus.b          = W'($urandom);
        bus.carryInput = 1'($urandom);
      end
      tick();
      lat++;
    end
    chk("op_outValid", W'(bus.outValid), W'(1));
    chk("op_sum", bus.sum, xs);
    chk("op_cout", W'(bus.carryOutput), W'(xc));
`ifdef SIGNED_OVF_EN
    chk("op_ovf", W'(bus.ovf), W'(xo));
`else
    if (xo === 1'bx) $display("note: xo unknown");
`endif
    for (int i = 0; i < hold; i++) begin
      bus.inValid    = ~bus.inValid;
      bus.a          = W'($urandom);
      bus.b          = W'($urandom);
      tick();
      chk("hold_outValid", W'(bus.outValid), W'(1));
      chk("hold_sum", bus.sum, xs);
      chk("hold_cout", W'(bus.carryOutput), W'(xc));
      chk("hold_inReady", W'(bus.inReady), W'(0));
    end
    bus.inValid  = 1'b0;
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
    chk("rel_outValid", W'(bus.outValid), W'(0));
    chk("rel_inReady", W'(bus.inReady), W'(1));
    chk("rel_sum", bus.sum, xs);
  endtask

  initial begin
    int lat;
    int acc[$];
    int n;
    rst            = 1'b1;
    bus.inValid    = 1'b0;
    bus.outReady   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.carryInput = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_inReady", W'(bus.inReady), W'(1));
    chk("rst_outValid", W'(bus.outValid), W'(0));
    chk("rst_sum", bus.sum, 16'h0000);
    chk("rst_cout", W'(bus.carryOutput), W'(0));

    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, lat);
    chk("latency", W'(lat), W'(5));

    run_op(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 10, 1'b0, lat);

    // Back-to-back with outReady held high: acceptances must be 6 cycles apart.
    bus.a          = 16'h1234;
    bus.b          = 16'h4321;
    bus.carryInput = 1'b1;
    bus.outReady   = 1'b1;
    bus.inValid    = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (bus.inReady) acc.push_back(i);
      if (bus.outValid) chk("b2b_sum", bus.sum, 16'h5556);
      tick();
    end
    bus.inValid = 1'b0;
    repeat (NIB + 3) tick();
    bus.outReady = 1'b0;
    chk("b2b_count", W'(acc.size()), W'(5));
    for (int i = 1; i < acc.size(); i++) chk("b2b_gap", W'(acc[i] - acc[i-1]), W'(6));

    // Reset on the second RUN edge aborts the operation.
    n = 0;
    while (!bus.inReady && n < 50) begin
      tick();
      n++;
    end
    bus.a       = 16'h1111;
    bus.b       = 16'h2222;
    bus.inValid = 1'b1;
    tick();
    bus.inValid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_outValid", W'(bus.outValid), W'(0));
    chk("abort_inReady", W'(bus.inReady), W'(1));
    chk("abort_sum", bus.sum, 16'h0000);
    run_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 0, 1'b0, lat);

    // Operands change every RUN cycle; result must use the accepted values.
    run_op(16'h8421, 16'h9999, 1'b1, 16'h1DBB, 1'b1, 1'b1, 2, 1'b1, lat);

    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0, lat);
    run_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0, lat);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b0, lat);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
